// File: rtl/pcie_lane_seq_pkg.sv
// Shared types and helpers for the PCIe lane-enable sequencer.
// Optional feature macro used by the top: PCIE_LANE_SEQ_LAT_EN (link latency counter).
package pcie_lane_seq_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_EN0,
        ST_EN1,
        ST_EN2,
        ST_EN3,
        ST_WAIT_LINK,
        ST_UP,
        ST_RETRY_CHK,
        ST_BACKOFF,
        ST_FAIL
    } state_t;

    localparam int RETRY_W = 8;

    // Width able to hold the larger of the two timer reload values.
    function automatic int timer_width(input int stage_dly, input int linkup_timeout);
        int m;
        m = (stage_dly > linkup_timeout) ? stage_dly : linkup_timeout;
        return $clog2(m + 1);
    endfunction

    // Lane groups that are enabled while the sequencer sits in a given state.
    function automatic logic [3:0] lane_mask(input state_t s);
        logic [3:0] m;
        case (s)
            ST_EN0:       m = 4'b0001;
            ST_EN1:       m = 4'b0011;
            ST_EN2:       m = 4'b0111;
            ST_EN3,
            ST_WAIT_LINK,
            ST_UP,
            ST_RETRY_CHK: m = 4'b1111;
            default:      m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/pcie_lane_seq_timer.sv
// Loadable saturating down-counter with a zero flag; never wraps below 0.
module pcie_lane_seq_timer #(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count_reg;

    // Load takes priority; otherwise count down and hold at zero.
    always_ff @(posedge CLK) begin
        if (RST) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/pcie_lane_en_seq.sv
// Lane-enable sequencer: staggers en0..en3, waits for link_up, retries with back-off.
// Define PCIE_LANE_SEQ_LAT_EN to add the link_lat latency counter output.
module pcie_lane_en_seq
    import pcie_lane_seq_pkg::*;
#(
    parameter int STAGE_DLY      = 256,
    parameter int LINKUP_TIMEOUT = 65536,
    parameter int MAX_RETRY      = 3
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               start,
    input  logic               link_up,
    output logic               en0,
    output logic               en1,
    output logic               en2,
    output logic               en3,
    output logic               busy,
    output logic               done,
    output logic               fail,
    output logic [RETRY_W-1:0] retry_cnt
`ifdef PCIE_LANE_SEQ_LAT_EN
    ,
    output logic [31:0]        link_lat
`endif
);

    localparam int TIMER_W = timer_width(STAGE_DLY, LINKUP_TIMEOUT);
    localparam logic [TIMER_W-1:0] STAGE_LOAD = TIMER_W'(STAGE_DLY - 1);
    localparam logic [TIMER_W-1:0] WAIT_LOAD  = TIMER_W'(LINKUP_TIMEOUT - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRY);

    state_t               state_reg;
    state_t               state_next;
    logic                 timer_load;
    logic [TIMER_W-1:0]   timer_load_val;
    logic                 timer_zero;
    logic [RETRY_W-1:0]   retry_cnt_reg;
    logic [RETRY_W-1:0]   retry_cnt_next;
    logic [3:0]           en_reg;
    logic                 busy_reg;
    logic                 done_reg;
    logic                 fail_reg;

    pcie_lane_seq_timer #(
        .W (TIMER_W)
    ) u_timer (
        .CLK      (CLK),
        .RST      (RST),
        .load     (timer_load),
        .load_val (timer_load_val),
        .zero     (timer_zero)
    );

    // Next-state decode; the timer is reloaded on entry to every timed state.
    always_comb begin
        state_next     = state_reg;
        timer_load     = 1'b0;
        timer_load_val = STAGE_LOAD;
        retry_cnt_next = retry_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next     = ST_EN0;
                    timer_load     = 1'b1;
                    retry_cnt_next = '0;
                end
            end
            ST_EN0: if (timer_zero) begin state_next = ST_EN1; timer_load = 1'b1; end
            ST_EN1: if (timer_zero) begin state_next = ST_EN2; timer_load = 1'b1; end
            ST_EN2: if (timer_zero) begin state_next = ST_EN3; timer_load = 1'b1; end
            ST_EN3: begin
                if (timer_zero) begin
                    state_next     = ST_WAIT_LINK;
                    timer_load     = 1'b1;
                    timer_load_val = WAIT_LOAD;
                end
            end
            ST_WAIT_LINK: begin
                // link_up beats a simultaneous timeout
                if (link_up) begin
                    state_next = ST_UP;
                end else if (timer_zero) begin
                    state_next = ST_RETRY_CHK;
                end
            end
            ST_UP: if (!link_up) state_next = ST_RETRY_CHK;
            ST_RETRY_CHK: begin
                if (retry_cnt_reg == RETRY_MAX) begin
                    state_next = ST_FAIL;
                end else begin
                    state_next     = ST_BACKOFF;
                    retry_cnt_next = retry_cnt_reg + 1'b1;
                    timer_load     = 1'b1;
                end
            end
            ST_BACKOFF: if (timer_zero) begin state_next = ST_EN0; timer_load = 1'b1; end
            ST_FAIL: state_next = ST_FAIL;
            default: state_next = ST_IDLE;
        endcase
    end

    // State register and status outputs, registered from the current state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg     <= ST_IDLE;
            retry_cnt_reg <= '0;
            en_reg        <= 4'b0000;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            fail_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            retry_cnt_reg <= retry_cnt_next;
            en_reg        <= lane_mask(state_reg);
            busy_reg      <= (state_reg != ST_IDLE) && (state_reg != ST_UP) && (state_reg != ST_FAIL);
            done_reg      <= (state_reg == ST_UP);
            fail_reg      <= (state_reg == ST_FAIL);
        end
    end

    assign en0       = en_reg[0];
    assign en1       = en_reg[1];
    assign en2       = en_reg[2];
    assign en3       = en_reg[3];
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign fail      = fail_reg;
    assign retry_cnt = retry_cnt_reg;

`ifdef PCIE_LANE_SEQ_LAT_EN
    logic [31:0] lat_reg;

    // Cycles since the latest EN0 entry; frozen while the link is up, saturating.
    always_ff @(posedge CLK) begin
        if (RST) begin
            lat_reg <= '0;
        end else if ((state_reg != ST_EN0) && (state_next == ST_EN0)) begin
            lat_reg <= '0;
        end else if ((state_reg != ST_UP) && (lat_reg != 32'hFFFF_FFFF)) begin
            lat_reg <= lat_reg + 32'd1;
        end
    end

    assign link_lat = lat_reg;
`endif

endmodule
